// File: rtl/dma_multi_channel_ctrl.sv
// Multi-channel DMA controller: round-robin channel arbitration, BR/BG bus takeover, line-wide device-to-memory writes.
// Optional cycle stealing (release the bus every BURST_LINES lines) is enabled with `define DMA_CYCLE_STEAL_EN.
module dma_multi_channel_ctrl #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned BURST_LINES = 3,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CH-1:0]               ch_start,
  input  logic [NUM_CH*WORD_SIZE-1:0]     ch_addr,
  input  logic [NUM_CH*WORD_SIZE-1:0]     ch_len,
  output logic [NUM_CH-1:0]               ch_busy,
  output logic [NUM_CH-1:0]               end_int,
  output logic                            BR,
  input  logic                            BG,
  output logic                            dev_rd,
  output logic [CH_W-1:0]                 dev_ch,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] dev_data,
  output logic                            d_writeM,
  output logic [WORD_SIZE-1:0]            d_address,
  output logic [LINE_WORDS*WORD_SIZE-1:0] d_data,
  input  logic                            d_done
);

  localparam int unsigned LW_SH = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_FETCH, S_WRITE, S_DONE, S_RELEASE
  } state_t;

  state_t               state, nxt;
  logic [CH_W-1:0]      cur, cur_nxt;
  logic [CH_W-1:0]      rr_ptr, rr_nxt;
  logic [WORD_SIZE-1:0] addr  [NUM_CH];
  logic [WORD_SIZE-1:0] lines [NUM_CH];
  logic [CH_W-1:0]      pick;
  logic                 pick_vld;
  int unsigned          idx;
  logic                 steal_hit;

  // First busy channel with lines left, scanning from rr_ptr with wrap
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      idx = (32'(rr_ptr) + 32'(k)) % NUM_CH;
      if (ch_busy[CH_W'(idx)] && (lines[CH_W'(idx)] != '0)) begin
        pick     = CH_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef DMA_CYCLE_STEAL_EN
  localparam int unsigned BC_W = $clog2(BURST_LINES + 1);
  logic [BC_W-1:0] burst_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)
      burst_cnt <= '0;
    else if ((state == S_RELEASE) || (state == S_IDLE))
      burst_cnt <= '0;
    else if ((state == S_WRITE) && d_done)
      burst_cnt <= burst_cnt + BC_W'(1);
  end

  assign steal_hit = (burst_cnt == BC_W'(BURST_LINES - 1));
`else
  assign steal_hit = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    cur_nxt = cur;
    rr_nxt  = rr_ptr;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          cur_nxt = pick;
          rr_nxt  = (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + CH_W'(1);
          nxt     = S_REQ;
        end
      end
      S_REQ:   if (BG) nxt = S_FETCH;
      S_FETCH: nxt = S_WRITE;
      S_WRITE: begin
        if (d_done) begin
          if (lines[cur] == WORD_SIZE'(1)) nxt = S_DONE;
          else if (steal_hit)              nxt = S_RELEASE;
          else                             nxt = S_FETCH;
        end
      end
      S_DONE:    nxt = S_RELEASE;
      S_RELEASE: if (!BG) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      rr_ptr    <= '0;
      ch_busy   <= '0;
      end_int   <= '0;
      BR        <= 1'b0;
      dev_rd    <= 1'b0;
      dev_ch    <= '0;
      d_writeM  <= 1'b0;
      d_address <= '0;
      d_data    <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        addr[i]  <= '0;
        lines[i] <= '0;
      end
    end else begin
      state    <= nxt;
      cur      <= cur_nxt;
      rr_ptr   <= rr_nxt;
      BR       <= (nxt == S_REQ) || (nxt == S_FETCH) || (nxt == S_WRITE);
      dev_rd   <= (nxt == S_FETCH);
      dev_ch   <= cur_nxt;
      d_writeM <= (nxt == S_WRITE);
      if (state == S_FETCH) begin
        d_address <= addr[cur];
        d_data    <= dev_data;
      end
      for (int i = 0; i < int'(NUM_CH); i++) begin
        end_int[i] <= 1'b0;
        // Zero-line channels complete on their own; the DONE channel is owned by the FSM
        if (ch_start[i] && !ch_busy[i]) begin
          addr[i]    <= ch_addr[i*WORD_SIZE +: WORD_SIZE];
          lines[i]   <= ch_len[i*WORD_SIZE +: WORD_SIZE] >> LW_SH;
          ch_busy[i] <= 1'b1;
        end else if (ch_busy[i] && (lines[i] == '0) &&
                     !((state == S_DONE) && (cur == CH_W'(i)))) begin
          ch_busy[i] <= 1'b0;
          end_int[i] <= 1'b1;
        end
        if ((state == S_DONE) && (cur == CH_W'(i)))
          ch_busy[i] <= 1'b0;
        if ((nxt == S_DONE) && (cur_nxt == CH_W'(i)))
          end_int[i] <= 1'b1;
        if ((state == S_WRITE) && d_done && (cur == CH_W'(i))) begin
          addr[i]  <= addr[i] + WORD_SIZE'(LINE_WORDS);
          lines[i] <= lines[i] - WORD_SIZE'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_multi_channel_ctrl.sv
// Directed bench for dma_multi_channel_ctrl: CPU grant, device and memory responders plus a write log.
module tb_dma_multi_channel_ctrl;

  localparam int unsigned WS = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NC-1:0]     ch_start;
  logic [NC*WS-1:0]  ch_addr;
  logic [NC*WS-1:0]  ch_len;
  logic [NC-1:0]     ch_busy;
  logic [NC-1:0]     end_int;
  logic              BR;
  logic              BG;
  logic              dev_rd;
  logic [CW-1:0]     dev_ch;
  logic [LW*WS-1:0]  dev_data;
  logic              d_writeM;
  logic [WS-1:0]     d_address;
  logic [LW*WS-1:0]  d_data;
  logic              d_done;

  dma_multi_channel_ctrl #(.WORD_SIZE(WS), .NUM_CH(NC), .LINE_WORDS(LW), .BURST_LINES(3)) dut (
    .clk(clk), .reset_n(reset_n), .ch_start(ch_start), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_busy(ch_busy), .end_int(end_int), .BR(BR), .BG(BG), .dev_rd(dev_rd), .dev_ch(dev_ch),
    .dev_data(dev_data), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data), .d_done(d_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int end_cnt [NC];
  logic br_seen;
  logic [WS-1:0]    log_addr [$];
  logic [LW*WS-1:0] log_data [$];

  function automatic logic [63:0] mk_line(input int ch, input int n);
    logic [63:0] l;
    l = '0;
    for (int k = 0; k < 4; k++) l[k*16 +: 16] = {4'(ch), 8'(n), 4'(k)};
    return l;
  endfunction

  assign dev_data = mk_line(32'(dev_ch), rd_cnt);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CPU grant follows BR two cycles late, both edges
  initial begin
    logic d1, d2;
    d1 = 1'b0; d2 = 1'b0; BG = 1'b0;
    forever begin
      @(posedge clk); #1;
      BG = d2; d2 = d1; d1 = BR;
    end
  end

  // Device line counter advances after the DUT has captured the line
  initial begin
    logic pend;
    pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pend) rd_cnt++;
      pend = dev_rd;
    end
  end

  // Memory: log each write, acknowledge three cycles after d_writeM rises
  initial begin
    int wcnt;
    wcnt = 0; d_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      d_done = 1'b0;
      if (d_writeM) begin
        if (wcnt == 0) begin
          log_addr.push_back(d_address);
          log_data.push_back(d_data);
        end
        wcnt++;
        if (wcnt == 3) begin
          d_done = 1'b1;
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NC); i++) if (end_int[i]) end_cnt[i]++;
      if (BR) br_seen = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clr_mon();
    for (int i = 0; i < int'(NC); i++) end_cnt[i] = 0;
    br_seen = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic set_ch(input int c, input logic [WS-1:0] a, input logic [WS-1:0] l);
    ch_addr[c*WS +: WS] = a;
    ch_len[c*WS +: WS]  = l;
  endtask

  task automatic pulse(input logic [NC-1:0] m);
    @(posedge clk); #1;
    ch_start = m;
    @(posedge clk); #1;
    ch_start = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int t, q;
    t = 0; q = 0;
    while (q < 4 && t < 3000) begin
      @(posedge clk); #1;
      t++;
      if (ch_busy == '0 && !BR && !BG && !d_writeM) q++;
      else q = 0;
    end
    chk(tag, 64'(t >= 3000), 64'(0));
  endtask

  task automatic exp_wr(input string tag, input int i, input int ch, input logic [WS-1:0] a, input int base);
    chk($sformatf("%s_wr%0d_present", tag, i), 64'(log_addr.size() > i), 64'(1));
    if (log_addr.size() > i) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), 64'(log_addr[i]), 64'(a));
      chk($sformatf("%s_wr%0d_data", tag, i), log_data[i], mk_line(ch, base + i));
    end
  endtask

  initial begin
    int base;
    int ech [7];
    logic [WS-1:0] ead [7];
    reset_n = 1'b0; ch_start = '0; ch_addr = '0; ch_len = '0;
    for (int i = 0; i < int'(NC); i++) end_cnt[i] = 0;
    br_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_br", 64'(BR), 64'(0));
    chk("rst_busy", 64'(ch_busy), 64'(0));
    chk("rst_end", 64'(end_int), 64'(0));
    chk("rst_wr", 64'(d_writeM), 64'(0));
    chk("rst_rd", 64'(dev_rd), 64'(0));
    chk("rst_addr", 64'(d_address), 64'(0));
    chk("rst_data", d_data, 64'(0));
    chk("rst_devch", 64'(dev_ch), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single channel, two lines
    clr_mon(); base = rd_cnt;
    set_ch(0, 16'h0100, 16'd8);
    pulse(4'b0001);
    chk("t1_busy_set", 64'(ch_busy[0]), 64'(1));
    wait_idle("t1_idle");
    chk("t1_nwr", 64'(log_addr.size()), 64'(2));
    exp_wr("t1", 0, 0, 16'h0100, base);
    exp_wr("t1", 1, 0, 16'h0104, base);
    chk("t1_end0", 64'(end_cnt[0]), 64'(1));
    chk("t1_br", 64'(BR), 64'(0));
    chk("t1_busy", 64'(ch_busy[0]), 64'(0));

    // 2: zero length, then remainder dropped
    clr_mon();
    set_ch(1, 16'h0A00, 16'd0);
    pulse(4'b0010);
    wait_idle("t2a_idle");
    chk("t2_end1", 64'(end_cnt[1]), 64'(1));
    chk("t2_no_br", 64'(br_seen), 64'(0));
    chk("t2_nwr0", 64'(log_addr.size()), 64'(0));
    clr_mon(); base = rd_cnt;
    set_ch(2, 16'h0200, 16'd6);
    pulse(4'b0100);
    wait_idle("t2b_idle");
    chk("t2_nwr", 64'(log_addr.size()), 64'(1));
    exp_wr("t2", 0, 2, 16'h0200, base);
    chk("t2_end2", 64'(end_cnt[2]), 64'(1));

    // 3: round-robin from rr_ptr=0, then from rr_ptr=1
    do_reset();
    clr_mon(); base = rd_cnt;
    set_ch(0, 16'h0300, 16'd4);
    set_ch(2, 16'h0500, 16'd4);
    pulse(4'b0101);
    wait_idle("t3a_idle");
    chk("t3a_nwr", 64'(log_addr.size()), 64'(2));
    exp_wr("t3a", 0, 0, 16'h0300, base);
    exp_wr("t3a", 1, 2, 16'h0500, base);
    set_ch(0, 16'h0600, 16'd4);
    pulse(4'b0001);
    wait_idle("t3b_idle");
    clr_mon(); base = rd_cnt;
    set_ch(0, 16'h0700, 16'd4);
    set_ch(2, 16'h0800, 16'd4);
    pulse(4'b0101);
    wait_idle("t3c_idle");
    chk("t3c_nwr", 64'(log_addr.size()), 64'(2));
    exp_wr("t3c", 0, 2, 16'h0800, base);
    exp_wr("t3c", 1, 0, 16'h0700, base);
    chk("t3c_end0", 64'(end_cnt[0]), 64'(1));
    chk("t3c_end2", 64'(end_cnt[2]), 64'(1));

    // 4: long channel against a short one
    do_reset();
    clr_mon(); base = rd_cnt;
`ifdef DMA_CYCLE_STEAL_EN
    ech = '{0, 0, 0, 3, 0, 0, 0};
    ead = '{16'h1000, 16'h1004, 16'h1008, 16'h3000, 16'h100C, 16'h1010, 16'h1014};
`else
    ech = '{0, 0, 0, 0, 0, 0, 3};
    ead = '{16'h1000, 16'h1004, 16'h1008, 16'h100C, 16'h1010, 16'h1014, 16'h3000};
`endif
    set_ch(0, 16'h1000, 16'd24);
    set_ch(3, 16'h3000, 16'd4);
    pulse(4'b1001);
    wait_idle("t4_idle");
    chk("t4_nwr", 64'(log_addr.size()), 64'(7));
    for (int i = 0; i < 7; i++) exp_wr("t4", i, ech[i], ead[i], base);
    chk("t4_end0", 64'(end_cnt[0]), 64'(1));
    chk("t4_end3", 64'(end_cnt[3]), 64'(1));

    // 5: reset in the middle of a write, then restart
    clr_mon();
    set_ch(1, 16'h4000, 16'd8);
    pulse(4'b0010);
    for (int t = 0; t < 200 && !d_writeM; t++) begin
      @(posedge clk); #1;
    end
    chk("t5_wr_seen", 64'(d_writeM), 64'(1));
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_br", 64'(BR), 64'(0));
    chk("t5_wr", 64'(d_writeM), 64'(0));
    chk("t5_busy", 64'(ch_busy), 64'(0));
    chk("t5_rd", 64'(dev_rd), 64'(0));
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_end", 64'(end_cnt[1]), 64'(0));
    clr_mon(); base = rd_cnt;
    set_ch(1, 16'h4800, 16'd4);
    pulse(4'b0010);
    wait_idle("t5_idle");
    chk("t5_nwr", 64'(log_addr.size()), 64'(1));
    exp_wr("t5", 0, 1, 16'h4800, base);
    chk("t5_end1", 64'(end_cnt[1]), 64'(1));

    // 6: restart while busy is ignored; address wraps
    do_reset();
    clr_mon(); base = rd_cnt;
    set_ch(0, 16'hFFFC, 16'd8);
    pulse(4'b0001);
    chk("t6_busy_set", 64'(ch_busy[0]), 64'(1));
    set_ch(0, 16'h7000, 16'd4);
    pulse(4'b0001);
    wait_idle("t6_idle");
    chk("t6_nwr", 64'(log_addr.size()), 64'(2));
    exp_wr("t6", 0, 0, 16'hFFFC, base);
    exp_wr("t6", 1, 0, 16'h0000, base);
    chk("t6_end0", 64'(end_cnt[0]), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_multi_channel_ctrl.md
Name: dma_multi_channel_ctrl

Overview:
- Parametrised successor to the single-channel DMA/bus-grant path beside the pipelined CPU.
- Serves NUM_CH device channels, each programmed with a memory address and word length.
- Arbitrates round-robin, takes the data-memory bus from the CPU via BR/BG, and streams cache-line-wide writes from the device port to memory.
- Raises a per-channel end interrupt when each channel's transfer completes.

Parameters:
WORD_SIZE, 16, address/data word width
NUM_CH, 4, number of DMA channels (2..8)
LINE_WORDS, 4, words per memory write (power of 2; matches the 4-word line bus)
BURST_LINES, 3, lines moved per bus tenure when cycle stealing is compiled in (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
ch_start  input  NUM_CH  per-channel start pulse
ch_addr  input  NUM_CH*WORD_SIZE  channel i start address, bits [i*WORD_SIZE +: WORD_SIZE]
ch_len  input  NUM_CH*WORD_SIZE  channel i length in words, same packing
ch_busy  output  NUM_CH  channel accepted and not yet ended
end_int  output  NUM_CH  one-cycle end interrupt per channel
BR  output  1  bus request to CPU
BG  input  1  bus grant from CPU
dev_rd  output  1  one-cycle device line read strobe
dev_ch  output  CH_W  channel for dev_rd; CH_W = max(1, clog2(NUM_CH))
dev_data  input  LINE_WORDS*WORD_SIZE  device line, valid in the dev_rd cycle
d_writeM  output  1  memory write request
d_address  output  WORD_SIZE  line address
d_data  output  LINE_WORDS*WORD_SIZE  line write data
d_done  input  1  one-cycle memory write completion

Behaviour:
- Reset (reset_n=0 at a clk edge) clears everything, including mid-transfer: all ch_busy, end_int, BR, dev_rd, d_writeM = 0; d_address, d_data, dev_ch = 0; round-robin pointer = 0; FSM = IDLE. An aborted transfer produces no end_int.
- Accept:
  - ch_start[i] while ch_busy[i]=0 latches addr[i], lines[i] = ch_len[i] >> log2(LINE_WORDS) (low bits dropped), and sets ch_busy[i] next cycle.
  - ch_start[i] while busy is ignored.
  - Several channels may start in the same cycle; each is accepted independently.
- Zero length: lines=0 sets ch_busy[i] for one cycle, then pulses end_int[i]. No BR. Handled outside the FSM; it may overlap an active transfer.
- FSM states:
  - IDLE: if any busy channel has lines>0, pick the first such channel at or after rr_ptr (wrapping); cur <= it; rr_ptr <= cur+1 mod NUM_CH; -> REQ. Arbitration takes 1 cycle.
  - REQ: BR=1; wait for BG=1 -> FETCH.
  - FETCH: dev_rd=1 and dev_ch=cur for exactly one cycle; capture dev_data into the line register -> WRITE.
  - WRITE: d_writeM=1, d_address=addr[cur], d_data=line, all stable until d_done. On d_done: addr[cur] += LINE_WORDS (mod 2^WORD_SIZE, wraps silently); lines[cur] -= 1; burst_cnt += 1. Then:
    - lines[cur]=0 -> DONE.
    - else cycle-steal release condition (see Optional Feature) -> RELEASE.
    - else -> FETCH.
  - DONE: end_int[cur]=1 for one cycle; ch_busy[cur] clears next cycle; BR=0 -> RELEASE.
  - RELEASE: BR=0, burst_cnt=0; wait for BG=0 -> IDLE.
- BR is registered: it is high from the cycle after entering REQ until leaving WRITE.
- BG is sampled only in REQ and RELEASE. A BG drop during FETCH/WRITE is a CPU protocol violation and is not detected.
- Per line, from BG high: 1 cycle FETCH, then WRITE until d_done. Back-to-back lines inside one tenure cost 1 extra FETCH cycle.
- A ch_start on channel cur during its DONE cycle is ignored (busy is still 1).

Optional Feature:
- Macro DMA_CYCLE_STEAL_EN.
- Defined: after burst_cnt reaches BURST_LINES with lines remaining, go to RELEASE. This drops BR, waits for BG=0, and re-arbitrates in IDLE, so other channels interleave and the CPU regains the bus between bursts.
- Undefined: the bus is held until the current channel completes. burst_cnt logic is removed.

Test Plan:
1. ch0 start addr=0x0100 len=8, BG follows BR +2 cycles, d_done 3 cycles after each d_writeM -> writes at 0x0100, 0x0104; end_int[0] one pulse; BR low afterward; ch_busy[0]=0.
2. ch1 len=0 -> end_int[1] pulses with BR never asserted. ch2 len=6 -> one line written at the start address (remainder dropped).
3. ch0 and ch2 start the same cycle, len=4 each, rr_ptr=0 -> ch0 served first, then ch2. A second run with rr_ptr=1 serves ch2 first.
4. With DMA_CYCLE_STEAL_EN, BURST_LINES=3, ch0 len=24 and ch3 len=4 -> ch0 writes 3 lines, BR drops, ch3's line is written, then ch0 resumes at 0x...+12. Without the macro: all 6 ch0 lines first.
5. reset_n=0 during WRITE of ch1 -> next cycle BR=0, d_writeM=0, ch_busy=0, no end_int. A restart after reset begins at the new ch_addr.
6. ch_start[0] re-pulsed while busy with a different addr -> ignored; the original address sequence continues. Address 0xFFFC len=8 -> second line written at 0x0000.
